// File: rtl/rx_bit_decoder_if.sv
// Raw D+/D- lines in, decoded bit stream and framing strobes out.
// master: the bit decoder; slave: the line driver / RX control FSM side.
interface rx_bit_decoder_if;
   logic        d_plus_in;
   logic        d_minus_in;
   logic        decoded_bit;
   logic        shift_en;
   logic        byte_done;
   logic [15:0] sr_val;
   logic        eop;
   logic        stuff_error;

   modport master (
      input  d_plus_in, d_minus_in,
      output decoded_bit, shift_en, byte_done, sr_val, eop, stuff_error
   );

   modport slave (
      output d_plus_in, d_minus_in,
      input  decoded_bit, shift_en, byte_done, sr_val, eop, stuff_error
   );
endinterface

// File: rtl/rx_bit_decoder.sv
// USB FS RX front end: sync, oversampled bit recovery, NRZI, unstuffing, EOP; RX_STUFF_ERR_EN enables stuff-error abort.
// Latency: line edge seen 3 clk after transition, outputs 1 clk after sample; no backpressure, every strobe must be taken.
module rx_bit_decoder #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   rx_bit_decoder_if.master rx
);
   localparam int            CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_EOP
   } state_e;

   logic          dp_s1_q, dp_s2_q, dp_d1_q;
   logic          dm_s1_q, dm_s2_q;

   state_e        state_q,     state_d;
   logic [CW-1:0] cnt_q,       cnt_d;
   logic          prev_dp_q,   prev_dp_d;
   logic [2:0]    ones_q,      ones_d;
   logic [2:0]    bit_cnt_q,   bit_cnt_d;
   logic [15:0]   sr_q,        sr_d;
   logic          dec_bit_q,   dec_bit_d;
   logic          shift_en_q,  shift_en_d;
   logic          byte_done_q, byte_done_d;
   logic          eop_q,       eop_d;
`ifdef RX_STUFF_ERR_EN
   logic          stuff_err_q, stuff_err_d;
`endif

   logic edge_det, sample, se0, line_j, nrzi_bit;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         dp_s1_q <= 1'b1;
         dp_s2_q <= 1'b1;
         dp_d1_q <= 1'b1;
         dm_s1_q <= 1'b0;
         dm_s2_q <= 1'b0;
      end else begin
         dp_s1_q <= rx.d_plus_in;
         dp_s2_q <= dp_s1_q;
         dp_d1_q <= dp_s2_q;
         dm_s1_q <= rx.d_minus_in;
         dm_s2_q <= dm_s1_q;
      end
   end

   // Only D+ transitions retime the counter; D- is used for SE0/J classification.
   assign edge_det = dp_s2_q ^ dp_d1_q;
   assign sample   = (cnt_q == CNT_MID);
   assign se0      = !dp_s2_q && !dm_s2_q;
   assign line_j   = dp_s2_q && !dm_s2_q;
   assign nrzi_bit = (dp_s2_q == prev_dp_q);

   always_comb begin
      state_d     = state_q;
      prev_dp_d   = prev_dp_q;
      ones_d      = ones_q;
      bit_cnt_d   = bit_cnt_q;
      sr_d        = sr_q;
      dec_bit_d   = dec_bit_q;
      shift_en_d  = 1'b0;
      byte_done_d = 1'b0;
      eop_d       = eop_q;
`ifdef RX_STUFF_ERR_EN
      stuff_err_d = 1'b0;
`endif
      if (edge_det || cnt_q == CNT_MAX) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (edge_det) begin
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (sample) begin
               prev_dp_d = dp_s2_q;
               if (se0) begin
                  state_d   = ST_EOP;
                  eop_d     = 1'b1;
                  bit_cnt_d = 3'd0;
                  ones_d    = 3'd0;
               end else begin
                  dec_bit_d = nrzi_bit;
                  // Six ones in a row: this bit is the stuffed one and never reaches the shift register.
                  if (ones_q == 3'd6) begin
                     ones_d = 3'd0;
`ifdef RX_STUFF_ERR_EN
                     if (nrzi_bit) begin
                        stuff_err_d = 1'b1;
                        state_d     = ST_EOP;
                        bit_cnt_d   = 3'd0;
                     end
`endif
                  end else begin
                     shift_en_d  = 1'b1;
                     sr_d        = {sr_q[14:0], nrzi_bit};
                     bit_cnt_d   = bit_cnt_q + 3'd1;
                     byte_done_d = (bit_cnt_q == 3'd7);
                     ones_d      = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                  end
               end
            end
         end
         ST_EOP: begin
            if (sample) begin
               if (line_j) begin
                  state_d   = ST_IDLE;
                  eop_d     = 1'b0;
                  prev_dp_d = 1'b1;
                  bit_cnt_d = 3'd0;
                  ones_d    = 3'd0;
               end else begin
                  prev_dp_d = dp_s2_q;
                  if (se0) begin
                     eop_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         prev_dp_q   <= 1'b1;
         ones_q      <= 3'd0;
         bit_cnt_q   <= 3'd0;
         sr_q        <= 16'h0000;
         dec_bit_q   <= 1'b1;
         shift_en_q  <= 1'b0;
         byte_done_q <= 1'b0;
         eop_q       <= 1'b0;
`ifdef RX_STUFF_ERR_EN
         stuff_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prev_dp_q   <= prev_dp_d;
         ones_q      <= ones_d;
         bit_cnt_q   <= bit_cnt_d;
         sr_q        <= sr_d;
         dec_bit_q   <= dec_bit_d;
         shift_en_q  <= shift_en_d;
         byte_done_q <= byte_done_d;
         eop_q       <= eop_d;
`ifdef RX_STUFF_ERR_EN
         stuff_err_q <= stuff_err_d;
`endif
      end
   end

   assign rx.decoded_bit = dec_bit_q;
   assign rx.shift_en    = shift_en_q;
   assign rx.byte_done   = byte_done_q;
   assign rx.sr_val      = sr_q;
   assign rx.eop         = eop_q;
`ifdef RX_STUFF_ERR_EN
   assign rx.stuff_error = stuff_err_q;
`else
   assign rx.stuff_error = 1'b0;
`endif
endmodule

// File: doc/rx_bit_decoder.md
# rx_bit_decoder

Front end of the USB full-speed RX path, directly upstream of the RX control FSM. Synchronises the raw D+/D- lines, recovers bit timing by oversampling, NRZI-decodes, removes stuffed bits and detects SE0/EOP. Shifts decoded bits into a 16-bit register and produces `decoded_bit`, `byte_done`, `sr_val` and `eop` for the control FSM, plus a per-bit strobe for the CRC checkers.

## Interface
- `CLKS_PER_BIT`, default 8: clk cycles per USB bit. Must be even and ≥ 6.
- `clk` in 1: system clock.
- `n_rst` in 1: asynchronous, active-low reset.
- `d_plus_in` in 1: raw D+, asynchronous to clk.
- `d_minus_in` in 1: raw D-, asynchronous to clk.
- `decoded_bit` out 1: last NRZI-decoded bit, including stuffed bits.
- `shift_en` out 1: one-cycle pulse when a non-stuffed data bit enters `sr_val`. Drives the CRC units.
- `byte_done` out 1: one-cycle pulse on the 8th data bit of each byte.
- `sr_val` out 16: receive shift register.
- `eop` out 1: level, high while SE0 is sampled.
- `stuff_error` out 1: one-cycle pulse on a bit-stuffing violation.

## Operation
- **Synchroniser:** each line passes through 2 flops. Reset values are D+ = 1, D- = 0 (J state).
- **Edge detect:** `edge` = synchronised D+ differs from its value one cycle earlier.
- **Timing counter:**
  - Range 0..CLKS_PER_BIT-1; wraps to 0.
  - Forced to 0 on the cycle after `edge`.
  - `sample` strobe when count == CLKS_PER_BIT/2-1.
- **FSM states:**
  - IDLE → ACTIVE on the first `edge` (J→K); the counter starts at 0.
  - ACTIVE → EOP on a `sample` of SE0 (D+ = 0 and D- = 0).
  - EOP → IDLE on a `sample` of J.
  - IDLE ignores `sample`.
- **NRZI decode** at each ACTIVE `sample`:
  - bit = 1 if sampled D+ equals `prev_dp`, else 0.
  - `prev_dp` updates on every sample.
  - `prev_dp` = 1 on reset and on entry to IDLE.
- **Unstuffing:**
  - A ones counter (0..6) increments on a 1 and clears on a 0.
  - The bit following six consecutive 1s is a stuffed bit: it is dropped (no `shift_en`) and clears the counter.
  - If that bit is 1, `stuff_error` pulses (see Configuration).
- **Shift register:** on a data bit, `sr_val <= {sr_val[14:0], bit}`. The first-received bit moves toward the MSB, so after a sync byte `sr_val[7:0]` = 8'b00000001.
- **Bit counter:**
  - 3-bit, increments per data bit.
  - `byte_done` pulses when it wraps 7→0.
  - Cleared on entry to IDLE and on entry to EOP.
- `sr_val` holds its value through EOP and IDLE and is overwritten only by new bits.

## Timing
- Reset values:
  - `decoded_bit` = 1; `shift_en`, `byte_done`, `eop`, `stuff_error` = 0.
  - `sr_val` = 0; state IDLE; all counters 0; `prev_dp` = 1.
- Latency: line transition → `edge` in 3 clk cycles. `sample` → `decoded_bit`, `shift_en`, `sr_val`, `byte_done` registered and valid 1 cycle later.
- `byte_done` and `shift_en` assert in the same cycle. `sr_val` already contains the new bit in that cycle.
- `eop`:
  - Rises 1 cycle after the first SE0 `sample`.
  - Falls 1 cycle after the J `sample` that returns the block to IDLE.
  - `eop` never coincides with `shift_en`; SE0 samples are not data.
- An edge within ±1 clk of a count wrap resynchronises without producing a double or missed `sample`, for bit periods of CLKS_PER_BIT±1.
- Asserting `n_rst` mid-packet returns every output to its reset value immediately (asynchronous). The next packet decodes normally.
- An SE0 sampled while the ones counter is at 6 is treated as EOP, not a stuff error.

## Configuration
- `RX_STUFF_ERR_EN` defined:
  - A 1 in the stuffed position pulses `stuff_error`.
  - The bit is still dropped.
  - The FSM moves to EOP-wait (IDLE on the next J sample).
- `RX_STUFF_ERR_EN` undefined:
  - `stuff_error` is tied to 0.
  - The stuffed-position bit is dropped silently regardless of value.
  - No state change.

## Test plan
- Sync byte KJKJKJKK at 8 clk/bit from idle J → exactly one `byte_done` pulse, `sr_val[7:0]` = 8'h01 in that cycle, 8 `shift_en` pulses.
- Sync, then data 8'hFF with a stuffed 0 after the sixth 1 → 16 `shift_en` pulses total (stuffed bit not counted), 2 `byte_done` pulses, `sr_val[7:0]` = 8'hFF.
- Sync, then seven consecutive 1s with no stuff → with `RX_STUFF_ERR_EN`, `stuff_error` pulses once and no `byte_done` follows. Without the macro, `stuff_error` stays 0.
- Sync, then 2 bit-times SE0, then J → `eop` high from 1 cycle after the first SE0 sample to 1 cycle after the J sample, state returns to IDLE, bit counter 0.
- Two full packets at bit periods of 7 and 9 clk (drift) → identical `sr_val` and `byte_done` sequence as the 8-clk case.
- `n_rst` pulsed low during the 4th bit of a byte → all outputs at reset values. The following sync byte yields `byte_done` with `sr_val[7:0]` = 8'h01.
